// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: fetch/issue sequencer that owns pc, epc, the retired count
// and a fetch-timeout bus-error trap.
module pc_seq_ctrl #(
    parameter logic [29:0] RESET_PC = 30'h0c00,
    parameter logic [29:0] EXC_VEC  = 30'h1060,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_ack,
    input  logic        exe_done,
    input  logic        stall,
    input  logic        exc_req,
    input  logic        eret,
    input  logic        jmp,
    input  logic [29:0] jmp_target,
    input  logic        br_taken,
    input  logic [29:0] br_target,
    output logic [29:0] pc,
    output logic [29:0] npc,
    output logic        if_req,
    output logic        ir_wr,
    output logic        instr_valid,
    output logic        pc_wr,
    output logic [29:0] epc,
    output logic        bus_err,
    output logic [31:0] retired
);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
    localparam logic [1:0] BOOT = 2'd0, FETCH = 2'd1, ISSUE = 2'd2;

    logic [1:0]    state;
    logic [TW-1:0] tcnt;

    always_comb begin
        if_req      = state == FETCH;
        ir_wr       = if_req && if_ack;
        instr_valid = state == ISSUE;
        pc_wr       = instr_valid && exe_done && !stall;
        npc         = !instr_valid ? pc :
                      exc_req      ? EXC_VEC :
                      eret         ? epc :
                      jmp          ? jmp_target :
                      br_taken     ? br_target : pc + 30'd1;
    end

    // Reset is active-low and asynchronous; an aborted instruction never commits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= BOOT;
            pc      <= RESET_PC;
            epc     <= '0;
            retired <= '0;
            bus_err <= 1'b0;
            tcnt    <= '0;
        end else if (state == BOOT) begin
            state <= FETCH;
            tcnt  <= '0;
        end else if (state == FETCH) begin
            if (if_ack)
                state <= ISSUE;
            else if (tcnt == TMAX) begin
                pc      <= EXC_VEC;
                epc     <= pc;
                bus_err <= 1'b1;
                tcnt    <= '0;
            end else
                tcnt <= tcnt + TW'(1);
        end else if (pc_wr) begin
            pc    <= npc;
            state <= FETCH;
            tcnt  <= '0;
            if (exc_req)
                epc <= pc;
            else
                retired <= retired + 32'd1;
        end else if (state != ISSUE)
            state <= BOOT;
    end
endmodule
